map_ctrl: RTL and testbench

MAP_CTRL -- requirements
Module: map_ctrl

---
 rtl/map_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_map_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/map_ctrl.sv
// ============================================================================
// Module      : map_ctrl
// Description : Tile-map controller. Copies a level from ROM into tile RAM,
//               serves renderer tile reads with a fixed one-cycle latency, and
//               resolves bullet hits from two round-robin requesters with
//               read-modify-write of brick tiles.
// Options     : define MAP_CTRL_BRICK_DAMAGE_EN for multi-hit bricks (each hit
//               decrements the brick state; the last hit turns it into air).
//               Without it a single hit destroys any brick.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module map_ctrl #(
  parameter int MAP_DIM = 13
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       load_i,
  output logic       busy_o,
  output logic [7:0] rom_addr_o,
  input  logic [6:0] rom_data_i,
  output logic [7:0] ram_addr_o,
  output logic       ram_we_o,
  output logic [6:0] ram_wdata_o,
  input  logic [6:0] ram_rdata_i,
  input  logic       render_req_i,
  input  logic [3:0] render_x_i,
  input  logic [3:0] render_y_i,
  output logic       render_valid_o,
  output logic [2:0] render_type_o,
  output logic [3:0] render_state_o,
  input  logic [1:0] hit_valid_i,
  input  logic [7:0] hit_x_i,
  input  logic [7:0] hit_y_i,
  output logic [1:0] hit_ready_o,
  output logic [1:0] hit_resp_valid_o,
  output logic       hit_solid_o
);

  localparam logic [7:0] DIM    = 8'(MAP_DIM);
  localparam logic [7:0] NTILES = 8'(MAP_DIM * MAP_DIM);

  localparam logic [2:0] T_BRICK = 3'b000;
  localparam logic [2:0] T_WALL  = 3'b001;
  localparam logic [2:0] T_AIR   = 3'b111;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    HIT_RD  = 3'd2,
    HIT_MOD = 3'd3,
    HIT_WR  = 3'd4
  } state_t;

  state_t     state;
  logic [7:0] load_cnt;     // LOAD cycle index: 0..NTILES
  logic       load_pend;    // load requested while a hit was in flight
  logic       last_grant;   // requester granted last; 1 after reset so req0 wins first
  logic       hit_id;
  logic [3:0] hit_x;
  logic [3:0] hit_y;
  logic       hit_oob;
  logic [6:0] wr_tile;
  logic       rend_valid;
  logic       rend_air;

  logic       in_load;
  logic       render_own;
  logic       render_oob;
  logic [7:0] render_addr;
  logic [7:0] hit_addr;
  logic       grant_id;
  logic [3:0] sel_x;
  logic [3:0] sel_y;
  logic       sel_oob;
  logic       hit_start;
  logic [2:0] mod_type;
  logic       mod_resp;
  logic       wr_resp;
  logic [6:0] brick_next;

  assign in_load     = (state == LOAD);
  // The renderer preempts the RAM port everywhere except during a level load.
  assign render_own  = rst_ni && render_req_i && !in_load;
  assign render_oob  = ({4'b0, render_x_i} >= DIM) || ({4'b0, render_y_i} >= DIM);
  assign render_addr = {4'b0, render_y_i} * DIM + {4'b0, render_x_i};
  assign hit_addr    = {4'b0, hit_y} * DIM + {4'b0, hit_x};

  // Round-robin pick: with both requesting, the one not granted last wins.
  always_comb begin
    grant_id = (hit_valid_i == 2'b11) ? ~last_grant : hit_valid_i[1];
    sel_x    = grant_id ? hit_x_i[7:4] : hit_x_i[3:0];
    sel_y    = grant_id ? hit_y_i[7:4] : hit_y_i[3:0];
    sel_oob  = ({4'b0, sel_x} >= DIM) || ({4'b0, sel_y} >= DIM);
  end

  // A pending or fresh load outranks any hit in IDLE.
  assign hit_start   = rst_ni && (state == IDLE) && !load_i && !load_pend && (|hit_valid_i);
  assign hit_ready_o = hit_start ? (grant_id ? 2'b10 : 2'b01) : 2'b00;

  // Hit response: out-of-range and non-brick tiles answer in HIT_MOD, bricks in HIT_WR.
  assign mod_type         = ram_rdata_i[6:4];
  assign mod_resp         = (state == HIT_MOD) && (hit_oob || (mod_type != T_BRICK));
  assign wr_resp          = (state == HIT_WR) && !render_own;
  assign hit_resp_valid_o = (mod_resp || wr_resp) ? (hit_id ? 2'b10 : 2'b01) : 2'b00;
  assign hit_solid_o      = wr_resp || (mod_resp && (hit_oob || (mod_type == T_WALL)));

  // Replacement value for a brick that has just been hit.
  always_comb begin
`ifdef MAP_CTRL_BRICK_DAMAGE_EN
    brick_next = (ram_rdata_i[3:0] == 4'd1) ? {T_AIR, 4'hF}
                                             : {T_BRICK, ram_rdata_i[3:0] - 4'd1};
`else
    brick_next = {T_AIR, 4'hF};
`endif
  end

  // RAM port owner: load copy, then renderer, then the in-flight hit.
  always_comb begin
    ram_addr_o  = 8'd0;
    ram_we_o    = 1'b0;
    ram_wdata_o = 7'd0;
    if (in_load) begin
      if (load_cnt != 8'd0) begin
        ram_we_o    = 1'b1;
        ram_addr_o  = load_cnt - 8'd1;
        ram_wdata_o = rom_data_i;
      end
    end else if (render_own) begin
      ram_addr_o = render_addr;
    end else if (state == HIT_RD) begin
      ram_addr_o = hit_addr;
    end else if (state == HIT_WR) begin
      ram_we_o    = 1'b1;
      ram_addr_o  = hit_addr;
      ram_wdata_o = wr_tile;
    end
  end

  assign busy_o     = in_load;
  assign rom_addr_o = (in_load && (load_cnt < NTILES)) ? load_cnt : 8'd0;

  // Render data arrives from RAM one cycle after the request; air when off-map or loading.
  assign render_valid_o = rend_valid;
  assign render_type_o  = rend_valid ? (rend_air ? T_AIR : ram_rdata_i[6:4]) : 3'b000;
  assign render_state_o = (rend_valid && !rend_air) ? ram_rdata_i[3:0] : 4'b0000;

  // Render request pipeline stage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rend_valid <= 1'b0;
      rend_air   <= 1'b0;
    end else begin
      rend_valid <= render_req_i;
      rend_air   <= in_load || render_oob;
    end
  end

  // Main controller: level load sequencing and hit read-modify-write.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      load_cnt   <= 8'd0;
      load_pend  <= 1'b0;
      last_grant <= 1'b1;
      hit_id     <= 1'b0;
      hit_x      <= 4'd0;
      hit_y      <= 4'd0;
      hit_oob    <= 1'b0;
      wr_tile    <= 7'd0;
    end else begin
      case (state)
        IDLE: begin
          if (load_i || load_pend) begin
            state     <= LOAD;
            load_cnt  <= 8'd0;
            load_pend <= 1'b0;
          end else if (|hit_valid_i) begin
            hit_id     <= grant_id;
            last_grant <= grant_id;
            hit_x      <= sel_x;
            hit_y      <= sel_y;
            hit_oob    <= sel_oob;
            state      <= sel_oob ? HIT_MOD : HIT_RD;
          end
        end
        LOAD: begin
          if (load_cnt == NTILES) begin
            state <= IDLE;
          end else begin
            load_cnt <= load_cnt + 8'd1;
          end
        end
        HIT_RD: begin
          if (load_i) load_pend <= 1'b1;
          if (!render_req_i) state <= HIT_MOD;
        end
        HIT_MOD: begin
          if (load_i) load_pend <= 1'b1;
          wr_tile <= brick_next;
          state   <= (!hit_oob && (mod_type == T_BRICK)) ? HIT_WR : IDLE;
        end
        HIT_WR: begin
          if (load_i) load_pend <= 1'b1;
          if (!render_req_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_map_ctrl.sv
// ============================================================================
// Module      : tb_map_ctrl
// Description : Self-checking bench for map_ctrl with ROM/RAM models and a
//               tile-map reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_map_ctrl;

  localparam int D = 13;
  localparam int N = D * D;
`ifdef MAP_CTRL_BRICK_DAMAGE_EN
  localparam logic [6:0] EXP16 = 7'h0E;
`else
  localparam logic [6:0] EXP16 = 7'h7F;
`endif

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b1;
  logic       load_i = 1'b0;
  logic       busy_o;
  logic [7:0] rom_addr_o;
  logic [6:0] rom_data_i;
  logic [7:0] ram_addr_o;
  logic       ram_we_o;
  logic [6:0] ram_wdata_o;
  logic [6:0] ram_rdata_i;
  logic       render_req_i = 1'b0;
  logic [3:0] render_x_i = 4'd0;
  logic [3:0] render_y_i = 4'd0;
  logic       render_valid_o;
  logic [2:0] render_type_o;
  logic [3:0] render_state_o;
  logic [1:0] hit_valid_i = 2'b00;
  logic [7:0] hit_x_i = 8'd0;
  logic [7:0] hit_y_i = 8'd0;
  logic [1:0] hit_ready_o;
  logic [1:0] hit_resp_valid_o;
  logic       hit_solid_o;

  map_ctrl #(.MAP_DIM(D)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .load_i(load_i), .busy_o(busy_o),
    .rom_addr_o(rom_addr_o), .rom_data_i(rom_data_i),
    .ram_addr_o(ram_addr_o), .ram_we_o(ram_we_o), .ram_wdata_o(ram_wdata_o),
    .ram_rdata_i(ram_rdata_i),
    .render_req_i(render_req_i), .render_x_i(render_x_i), .render_y_i(render_y_i),
    .render_valid_o(render_valid_o), .render_type_o(render_type_o),
    .render_state_o(render_state_o),
    .hit_valid_i(hit_valid_i), .hit_x_i(hit_x_i), .hit_y_i(hit_y_i),
    .hit_ready_o(hit_ready_o), .hit_resp_valid_o(hit_resp_valid_o),
    .hit_solid_o(hit_solid_o)
  );

  always #5 clk_i = ~clk_i;

  // ROM / RAM environment models, one-cycle read latency, plus a backdoor write.
  logic [6:0] rom [0:255];
  logic [6:0] mem [0:255];
  logic       bd_we = 1'b0;
  logic [7:0] bd_addr = 8'd0;
  logic [6:0] bd_data = 7'd0;

  always @(posedge clk_i) begin
    rom_data_i  <= rom[rom_addr_o];
    ram_rdata_i <= mem[ram_addr_o];
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (ram_we_o) mem[ram_addr_o] <= ram_wdata_o;
  end

  // Reference model state
  logic [6:0] ref_map [0:N-1];
  logic       last_g = 1'b1;
  logic       pend_req = 1'b0;
  logic [6:0] pend_exp = 7'd0;
  int         n_cmp = 0;
  int         n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] hit_brick(input logic [6:0] t);
`ifdef MAP_CTRL_BRICK_DAMAGE_EN
    if (t[3:0] == 4'd1) return 7'h7F;
    return {3'b000, t[3:0] - 4'd1};
`else
    return 7'h7F;
`endif
  endfunction

  // One clock cycle: drive inputs after the edge, sample at the falling edge,
  // and check the render answer to the previous cycle's request.
  task automatic step(input logic rq, input logic [1:0] hv, input logic ld);
    int rx, ry;
    @(posedge clk_i); #1;
    rx = int'($urandom_range(0, 15));
    ry = int'($urandom_range(0, 15));
    render_req_i = rq;
    render_x_i   = 4'(rx);
    render_y_i   = 4'(ry);
    hit_valid_i  = hv;
    load_i       = ld;
    @(negedge clk_i);
    chk("render_valid", 32'(render_valid_o), 32'(pend_req));
    if (pend_req) chk("render_data", 32'({render_type_o, render_state_o}), 32'(pend_exp));
    pend_req = rq;
    if (rq) pend_exp = (rx >= D || ry >= D || busy_o) ? 7'h70 : ref_map[ry*D+rx];
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"},   32'(busy_o), 0);
    chk({tag, "_rom"},    32'(rom_addr_o), 0);
    chk({tag, "_raddr"},  32'(ram_addr_o), 0);
    chk({tag, "_we"},     32'(ram_we_o), 0);
    chk({tag, "_wdata"},  32'(ram_wdata_o), 0);
    chk({tag, "_rvalid"}, 32'(render_valid_o), 0);
    chk({tag, "_rtile"},  32'({render_type_o, render_state_o}), 0);
    chk({tag, "_ready"},  32'(hit_ready_o), 0);
    chk({tag, "_resp"},   32'(hit_resp_valid_o), 0);
    chk({tag, "_solid"},  32'(hit_solid_o), 0);
  endtask

  task automatic do_reset();
    @(posedge clk_i); #1;
    rst_ni = 1'b0; render_req_i = 1'b1; hit_valid_i = 2'b11; load_i = 1'b1;
    @(negedge clk_i);
    chk_zero("reset");
    @(posedge clk_i); #1;
    rst_ni = 1'b1; render_req_i = 1'b0; hit_valid_i = 2'b00; load_i = 1'b0;
    pend_req = 1'b0;
    last_g   = 1'b1;
    step(0, 2'b00, 0); chk("no_autoload", 32'(busy_o), 0);
    step(0, 2'b00, 0); chk("no_autoload", 32'(busy_o), 0);
  endtask

  task automatic set_tile(input int a, input logic [6:0] v);
    bd_we = 1'b1; bd_addr = 8'(a); bd_data = v;
    step(0, 2'b00, 0);
    bd_we = 1'b0;
    ref_map[a] = v;
  endtask

  task automatic verify_mem();
    for (int i = 0; i < N; i++) chk("load_word", 32'(mem[i]), 32'(rom[i]));
  endtask

  // Follows an in-progress load: counts busy cycles, checks ROM addressing and
  // that renders and extra load pulses during the load are handled.
  task automatic count_load();
    int nb;
    nb = 0;
    for (int i = 0; i < N; i++) ref_map[i] = rom[i];
    for (int k = 0; k < 400; k++) begin
      step(1'($urandom_range(0, 1)), 2'b00,
           (nb > 5 && nb < 100) ? 1'($urandom_range(0, 1)) : 1'b0);
      if (!busy_o) break;
      if (nb < N) chk("rom_addr", 32'(rom_addr_o), 32'(nb));
      nb++;
    end
    chk("busy_cycles", 32'(nb), 32'(N + 1));
    verify_mem();
  endtask

  task automatic do_load();
    step(0, 2'b00, 1);
    chk("busy_at_pulse", 32'(busy_o), 0);
    count_load();
  endtask

  // One hit transaction. rp[k-1] is the render request in cycle T+k.
  task automatic run_hit(input logic [1:0] vm, input int x0, input int y0,
                         input int x1, input int y1, input logic [15:0] rp);
    int w, x, y, a, off, c, d;
    logic oob, wr, solid, rq;
    logic [6:0] t, nt;
    w   = (vm == 2'b11) ? (last_g ? 0 : 1) : (vm[1] ? 1 : 0);
    x   = w ? x1 : x0;
    y   = w ? y1 : y0;
    oob = (x >= D) || (y >= D);
    a   = oob ? 0 : y * D + x;
    wr = 1'b0; nt = 7'd0; solid = 1'b1; off = 1;
    if (!oob) begin
      c = 1;
      while (c <= 16 && rp[c-1]) c++;
      t = ref_map[a];
      if (t[6:4] == 3'b000) begin
        d = c + 2;
        while (d <= 16 && rp[d-1]) d++;
        off = d; wr = 1'b1; nt = hit_brick(t);
      end else begin
        off = c + 1;
        solid = (t[6:4] == 3'b001);
      end
    end
    hit_x_i = {4'(x1), 4'(x0)};
    hit_y_i = {4'(y1), 4'(y0)};
    step(0, vm, 0);
    chk("hit_ready", 32'(hit_ready_o), w ? 2 : 1);
    chk("hit_resp_T", 32'(hit_resp_valid_o), 0);
    last_g = w[0];
    for (int k = 1; k <= off; k++) begin
      rq = (k == off) ? 1'b0 : rp[k-1];
      step(rq, vm, 0);
      chk("hit_ready_busy", 32'(hit_ready_o), 0);
      chk("hit_resp", 32'(hit_resp_valid_o), (k == off) ? (w ? 2 : 1) : 0);
      if (k == off) chk("hit_solid", 32'(hit_solid_o), 32'(solid));
      chk("hit_we", 32'(ram_we_o), 32'(k == off && wr));
    end
    if (wr) ref_map[a] = nt;
    step(0, 2'b00, 0);
    if (!oob) chk("hit_word", 32'(mem[a]), 32'(ref_map[a]));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0] vm;
    int x0, y0, x1, y1;
    for (int i = 0; i < 256; i++) rom[i] = 7'($urandom);

    do_reset();
    do_load();

    // free-running renders against the loaded map
    for (int i = 0; i < 24; i++) step(1'($urandom_range(0, 1)), 2'b00, 0);
    step(0, 2'b00, 0);

    // brick at (3,1), requester 0, no contention
    set_tile(16, 7'h0F);
    run_hit(2'b01, 3, 1, 0, 0, 16'h0000);
    chk("brick16", 32'(mem[16]), 32'(EXP16));

    // both requesters after reset: req0 (wall) then req1 (tree)
    do_reset();
    set_tile(28, 7'h13);
    set_tile(56, 7'h25);
    run_hit(2'b11, 2, 2, 4, 4, 16'h0000);
    run_hit(2'b11, 2, 2, 4, 4, 16'h0000);

    // render stalls in HIT_RD, then in HIT_WR
    set_tile(97, 7'h03);
    run_hit(2'b01, 6, 7, 0, 0, 16'h0003);
    run_hit(2'b10, 0, 0, 6, 7, 16'h000C);

    // off-map hits and non-solid codes
    run_hit(2'b01, 13, 0, 0, 0, 16'h0000);
    run_hit(2'b10, 0, 0, 2, 15, 16'h0001);
    set_tile(0, 7'h45);
    run_hit(2'b01, 0, 0, 0, 0, 16'h0000);
    set_tile(1, 7'h3A);
    run_hit(2'b01, 1, 0, 0, 0, 16'h0001);

    // randomized hits
    for (int i = 0; i < 16; i++) begin
      vm = 2'($urandom_range(1, 3));
      x0 = int'($urandom_range(0, 14)); y0 = int'($urandom_range(0, 14));
      x1 = int'($urandom_range(0, 14)); y1 = int'($urandom_range(0, 14));
      if (x0 < D && y0 < D) set_tile(y0 * D + x0, 7'($urandom));
      if (x1 < D && y1 < D) set_tile(y1 * D + x1, 7'($urandom));
      run_hit(vm, x0, y0, x1, y1, 16'($urandom & $urandom & 32'h0000_00FF));
    end

    // reset while a brick write is stalled by the renderer
    set_tile(70, 7'h05);
    hit_x_i = 8'h05; hit_y_i = 8'h05;
    step(0, 2'b01, 0); chk("rst_wr_ready", 32'(hit_ready_o), 1);
    step(0, 2'b00, 0);
    step(0, 2'b00, 0); chk("rst_wr_mod", 32'(hit_resp_valid_o), 0);
    step(1, 2'b00, 0); chk("rst_wr_stall", 32'(ram_we_o), 0);
    @(posedge clk_i); #1;
    rst_ni = 1'b0; render_req_i = 1'b0;
    @(negedge clk_i);
    chk_zero("rst_wr");
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    pend_req = 1'b0;
    last_g = 1'b1;
    step(0, 2'b00, 0); chk("rst_wr_no_we", 32'(ram_we_o), 0);
    step(0, 2'b00, 0); chk("rst_wr_no_we", 32'(ram_we_o), 0);
    chk("rst_wr_word", 32'(mem[70]), 32'h05);

    // load requested during HIT_MOD of a wall hit
    set_tile(0, 7'h1A);
    hit_x_i = 8'h00; hit_y_i = 8'h00;
    step(0, 2'b01, 0); chk("pend_ready", 32'(hit_ready_o), 1);
    step(0, 2'b00, 0); chk("pend_rd", 32'(hit_resp_valid_o), 0);
    step(0, 2'b00, 1); chk("pend_resp", 32'(hit_resp_valid_o), 1);
    chk("pend_solid", 32'(hit_solid_o), 1);
    step(0, 2'b00, 0); chk("pend_idle", 32'(busy_o), 0);
    count_load();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
